// File: rtl/baud_gen_if.sv
// rtl/baud_gen_if.sv - control strobes and tick outputs shared by baud_gen and its user
interface baud_gen_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
);
  localparam int IDX_W = $clog2(OVERSAMPLE);

  logic                 En;
  logic                 DivLoad;
  logic [DIV_WIDTH-1:0] DivIn;
  logic                 Resync;
  logic                 SampleTick;
  logic                 BaudTick;
  logic [IDX_W-1:0]     SampleIdx;
  logic                 Clk;
  logic                 DivErr;

  modport master (
    output En, DivLoad, DivIn, Resync,
    input  SampleTick, BaudTick, SampleIdx, Clk, DivErr
  );

  modport slave (
    input  En, DivLoad, DivIn, Resync,
    output SampleTick, BaudTick, SampleIdx, Clk, DivErr
  );
endinterface

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - programmable baud/sample tick generator with bit-phase resync
module baud_gen #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16
) (
  input logic     SysClk,
  input logic     Rst,
  baud_gen_if.slave bus
);
  localparam int     IDX_W = $clog2(OVERSAMPLE);
  localparam longint DEF   = longint'(SYSCLK_RATE) / (longint'(BAUD_RATE) * longint'(OVERSAMPLE));
  localparam logic [DIV_WIDTH-1:0] DEF_W    = DIV_WIDTH'(DEF);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]     IDX_HALF = IDX_W'(OVERSAMPLE / 2);

  if (DEF < 2 || DEF >= (longint'(1) << DIV_WIDTH) || (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 2)
  begin : g_bad_params
    $error("baud_gen: illegal SYSCLK_RATE/BAUD_RATE/OVERSAMPLE/DIV_WIDTH combination");
  end

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 clk_q, clk_d;
  logic                 stick_q, stick_d;
  logic                 btick_q, btick_d;
  logic                 err_q, err_d;
  logic                 load_ok;

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    clk_d   = clk_q;
    stick_d = 1'b0;
    btick_d = 1'b0;
    err_d   = 1'b0;
    load_ok = bus.DivLoad && (bus.DivIn >= DIV_WIDTH'(2));

    if (load_ok) begin
      div_d = bus.DivIn;
      cnt_d = '0;
      idx_d = '0;
      clk_d = 1'b0;
    end else begin
      // A rejected load only reports; counting continues undisturbed.
      err_d = bus.DivLoad;
      if (bus.Resync) begin
        cnt_d = '0;
        idx_d = '0;
        clk_d = 1'b0;
      end else if (bus.En) begin
        if (cnt_q == div_q - DIV_WIDTH'(1)) begin
          cnt_d   = '0;
          stick_d = 1'b1;
          btick_d = (idx_q == IDX_LAST);
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          if (idx_d == IDX_HALF || idx_d == '0) begin
            clk_d = ~clk_q;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      div_q   <= DEF_W;
      cnt_q   <= '0;
      idx_q   <= '0;
      clk_q   <= 1'b0;
      stick_q <= 1'b0;
      btick_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      clk_q   <= clk_d;
      stick_q <= stick_d;
      btick_q <= btick_d;
      err_q   <= err_d;
    end
  end

  assign bus.SampleTick = stick_q;
  assign bus.BaudTick   = btick_q;
  assign bus.SampleIdx  = idx_q;
  assign bus.Clk        = clk_q;
  assign bus.DivErr     = err_q;
endmodule

// File: tb/tb_baud_gen.sv
// tb/tb_baud_gen.sv - self-checking bench for baud_gen
module tb_baud_gen;
  localparam int OS = 8;
  localparam int DW = 8;

  logic SysClk = 1'b0;
  logic Rst;

  baud_gen_if #(.DIV_WIDTH(DW), .OVERSAMPLE(OS)) bif ();

  baud_gen #(
    .SYSCLK_RATE(320),
    .BAUD_RATE  (4),
    .OVERSAMPLE (OS),
    .DIV_WIDTH  (DW)
  ) dut (
    .SysClk(SysClk),
    .Rst   (Rst),
    .bus   (bif.slave)
  );

  always #5 SysClk = ~SysClk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: m_k counts enabled cycles since the last realignment.
  int   m_d = 10;
  int   m_k = 0;
  logic m_st = 1'b0, m_bt = 1'b0, m_err = 1'b0, m_valid = 1'b0;

  int   st_q[$];
  int   bt_q[$];
  logic clk_hist [0:8191];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_gaps(input string name, input int q[$], input int gap);
    int mn = 1 << 30;
    int mx = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] - q[i-1] < mn) mn = q[i] - q[i-1];
      if (q[i] - q[i-1] > mx) mx = q[i] - q[i-1];
    end
    if (q.size() < 2) begin
      mn = -1;
      mx = -1;
    end
    check({name, " min gap"}, mn, gap);
    check({name, " max gap"}, mx, gap);
  endtask

  always @(posedge SysClk) begin
    cyc <= cyc + 1;
    if (Rst) begin
      m_d <= 10; m_k <= 0; m_st <= 1'b0; m_bt <= 1'b0; m_err <= 1'b0; m_valid <= 1'b1;
    end else if (bif.DivLoad && int'(bif.DivIn) >= 2) begin
      m_d <= int'(bif.DivIn); m_k <= 0; m_st <= 1'b0; m_bt <= 1'b0; m_err <= 1'b0;
    end else begin
      m_err <= bif.DivLoad;
      if (bif.Resync) begin
        m_k <= 0; m_st <= 1'b0; m_bt <= 1'b0;
      end else if (bif.En) begin
        m_k  <= m_k + 1;
        m_st <= ((m_k + 1) % m_d) == 0;
        m_bt <= ((m_k + 1) % (m_d * OS)) == 0;
      end else begin
        m_st <= 1'b0; m_bt <= 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge SysClk);
      if (m_valid) begin
        check("SampleTick", int'(bif.SampleTick), int'(m_st));
        check("BaudTick",   int'(bif.BaudTick),   int'(m_bt));
        check("SampleIdx",  int'(bif.SampleIdx),  (m_k / m_d) % OS);
        check("Clk",        int'(bif.Clk),        int'(((m_k / m_d) % OS) >= OS / 2));
        check("DivErr",     int'(bif.DivErr),     int'(m_err));
      end
      if (bif.SampleTick) st_q.push_back(cyc);
      if (bif.BaudTick)   bt_q.push_back(cyc);
      if (cyc < 8192) clk_hist[cyc] = bif.Clk;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge SysClk);
  endtask

  task automatic pulse_load(input int val);
    bif.DivLoad = 1'b1;
    bif.DivIn   = DW'(val);
    @(negedge SysClk);
    bif.DivLoad = 1'b0;
  endtask

  task automatic wait_baud(output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge SysClk);
      if (bif.BaudTick) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int hi, lo, r, b, b2, frz, found;
    Rst = 1'b1; bif.En = 1'b0; bif.DivLoad = 1'b0; bif.DivIn = '0; bif.Resync = 1'b0;
    step(3);
    check("reset SampleIdx", int'(bif.SampleIdx), 0);
    check("reset Clk", int'(bif.Clk), 0);

    // Free run at the default divisor.
    Rst = 1'b0; bif.En = 1'b1;
    st_q.delete(); bt_q.delete();
    step(200);
    check_gaps("run10 SampleTick", st_q, 10);
    check("run10 BaudTick count", bt_q.size(), 2);
    hi = 0; lo = 0;
    if (bt_q.size() >= 2) begin
      for (int c = bt_q[0]; c < bt_q[1]; c++) begin
        if (clk_hist[c]) hi++; else lo++;
      end
    end
    check("run10 Clk high cycles", hi, 40);
    check("run10 Clk low cycles", lo, 40);

    // Valid divisor load mid-bit, with Clk currently high.
    check("pre-load Clk", int'(bif.Clk), 1);
    pulse_load(3);
    check("load3 SampleIdx", int'(bif.SampleIdx), 0);
    check("load3 Clk", int'(bif.Clk), 0);
    st_q.delete(); bt_q.delete();
    step(60);
    check_gaps("run3 SampleTick", st_q, 3);
    check_gaps("run3 BaudTick", bt_q, 24);

    // Rejected divisor leaves spacing at 10.
    pulse_load(10);
    st_q.delete();
    step(15);
    pulse_load(1);
    check("DivErr pulse", int'(bif.DivErr), 1);
    step(1);
    check("DivErr clears", int'(bif.DivErr), 0);
    step(28);
    check_gaps("after bad load SampleTick", st_q, 10);

    // Resync at SampleIdx 5.
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (int'(bif.SampleIdx) == 5) begin
        found = 1;
        break;
      end
      @(negedge SysClk);
    end
    check("reached SampleIdx 5", found, 1);
    bif.Resync = 1'b1;
    @(negedge SysClk);
    bif.Resync = 1'b0;
    r = cyc;
    check("resync SampleIdx", int'(bif.SampleIdx), 0);
    check("resync Clk", int'(bif.Clk), 0);
    check("resync no tick", int'(bif.SampleTick), 0);
    wait_baud(b);
    check("resync to BaudTick", b - r, 80);

    // Enable dropped for 17 cycles mid-sample stretches the bit.
    step(25);
    frz = int'(bif.SampleIdx);
    bif.En = 1'b0;
    st_q.delete();
    step(17);
    bif.En = 1'b1;
    check("frozen ticks", st_q.size(), 0);
    check("frozen SampleIdx", int'(bif.SampleIdx), frz);
    wait_baud(b2);
    check("stretched bit", b2 - b, 97);

    // Reset wins over a simultaneous load and resync.
    pulse_load(5);
    Rst = 1'b1; bif.DivLoad = 1'b1; bif.DivIn = DW'(3); bif.Resync = 1'b1;
    @(negedge SysClk);
    Rst = 1'b0; bif.DivLoad = 1'b0; bif.Resync = 1'b0;
    check("combo SampleIdx", int'(bif.SampleIdx), 0);
    check("combo Clk", int'(bif.Clk), 0);
    check("combo DivErr", int'(bif.DivErr), 0);
    st_q.delete();
    step(35);
    check_gaps("after reset SampleTick", st_q, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
